// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the external 16-bit SRAM initiator.
//   state_t        : access FSM states
//   sram_req_t     : one queued client request (we, addr, wdata)
//   sram_strobe_t  : the five active-low SRAM strobes as one register
//   STROBE_*       : strobe patterns for idle, read and write cycles
// The request struct is sized by SRAM_ADDR_W / SRAM_DATA_W; the controller's
// ADDR_W / DATA_W parameters default to these and must stay equal to them.
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_TURN
    } state_t;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_req_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
    } sram_strobe_t;

    // Only full-word accesses exist, so UB_N/LB_N follow CE_N.
    localparam sram_strobe_t STROBE_IDLE  = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1};
    localparam sram_strobe_t STROBE_READ  = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0};
    localparam sram_strobe_t STROBE_WRITE = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b0, ub_n: 1'b0, lb_n: 1'b0};

endpackage

// File: rtl/sram_req_fifo.sv
// ---------------------------------------------------------------------------
// sram_req_fifo
// Synchronous first-word-fall-through FIFO of sram_req_t. The oldest entry is
// presented on o_head whenever o_empty is low; i_pop consumes it.
// Ports:
//   Clock_100  in   clock, rising edge
//   Resetn     in   asynchronous active-low reset; empties the FIFO
//   i_push     in   write i_req (ignored while o_full)
//   i_pop      in   consume o_head (ignored while o_empty)
//   i_req      in   request to store
//   o_head     out  oldest stored request
//   o_full     out  DEPTH entries stored
//   o_empty    out  no entries stored
// ---------------------------------------------------------------------------
module sram_req_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      Clock_100,
    input  logic      Resetn,
    input  logic      i_push,
    input  logic      i_pop,
    input  sram_req_t i_req,
    output sram_req_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // One extra wrap bit per pointer separates full from empty when the
    // index bits are equal.
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    sram_req_t      r_mem [DEPTH];
    logic           w_push_ok;
    logic           w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge Clock_100 or negedge Resetn) begin
        if (!Resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are valid, and leaving the array reset-free lets it
    // map onto plain flops or LUT RAM.
    always_ff @(posedge Clock_100) begin
        if (w_push_ok) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_req;
    end

    assign o_head = r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/sram_access_controller.sv
// ---------------------------------------------------------------------------
// sram_access_controller
// Initiator side of the external 16-bit asynchronous SRAM. Client word
// requests are queued in a small FIFO and issued to the pins at one access
// per cycle; a write followed by a read gets one idle turnaround cycle.
// Read data returns on a valid-only response port.
// Ports:
//   Clock_100     in     clock, rising edge
//   Resetn        in     asynchronous active-low reset
//   req_valid     in     client request present
//   req_ready     out    request FIFO not full
//   req_we        in     1 = write, 0 = read
//   req_addr      in     word address
//   req_wdata     in     write data (ignored for reads)
//   rd_valid      out    one-cycle pulse with rd_data / rd_addr
//   rd_data       out    read word
//   rd_addr       out    address of the returned read
//   busy          out    FIFO non-empty or an access on the pins
//   SRAM_data_io  inout  SRAM data bus, driven only in write cycles
//   SRAM_address  out    SRAM word address (held while idle)
//   SRAM_*_N      out    active-low SRAM strobes
// ---------------------------------------------------------------------------
module sram_access_controller
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock_100,
    input  logic              Resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    inout  wire  [DATA_W-1:0] SRAM_data_io,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic              SRAM_WE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    sram_req_t         w_req;
    sram_req_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_turn;

    state_t            r_state;
    sram_strobe_t      r_strobe;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_wdata;
    logic              r_drive_en;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W-1:0] r_rd_addr;

    assign w_req  = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign w_push = req_valid && !w_full;

    // A read waiting behind a write stays in the FIFO for one cycle while the
    // bus turns around; every other non-empty cycle issues the head.
    assign w_turn = (r_state == S_WRITE) && !w_head.we;
    assign w_pop  = !w_empty && !w_turn;

    sram_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock_100 (Clock_100),
        .Resetn    (Resetn),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_req     (w_req),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge Clock_100 or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_strobe   <= STROBE_IDLE;
            r_address  <= '0;
            r_wdata    <= '0;
            r_drive_en <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_addr  <= '0;
        end else begin
            // NOTE: non-blocking updates mean r_address below is still the
            // address of the read finishing on the pins this cycle, even
            // though a new address is being loaded on the same edge.
            r_rd_valid <= (r_state == S_READ);
            if (r_state == S_READ) begin
                r_rd_data <= SRAM_data_io;
                r_rd_addr <= r_address;
            end

            if (w_empty) begin
                r_state    <= S_IDLE;
                r_strobe   <= STROBE_IDLE;
                r_drive_en <= 1'b0;
            end else if (w_turn) begin
                r_state    <= S_TURN;
                r_strobe   <= STROBE_IDLE;
                r_drive_en <= 1'b0;
            end else if (w_head.we) begin
                r_state    <= S_WRITE;
                r_strobe   <= STROBE_WRITE;
                r_address  <= w_head.addr;
                r_wdata    <= w_head.wdata;
                r_drive_en <= 1'b1;
            end else begin
                r_state    <= S_READ;
                r_strobe   <= STROBE_READ;
                r_address  <= w_head.addr;
                r_drive_en <= 1'b0;
            end
        end
    end

    // drive_en and WE_N come from the same register update, so the bus is
    // released on exactly the edge that ends the write cycle.
    assign SRAM_data_io = r_drive_en ? r_wdata : 'z;

    assign SRAM_address = r_address;
    assign SRAM_CE_N    = r_strobe.ce_n;
    assign SRAM_OE_N    = r_strobe.oe_n;
    assign SRAM_WE_N    = r_strobe.we_n;
    assign SRAM_UB_N    = r_strobe.ub_n;
    assign SRAM_LB_N    = r_strobe.lb_n;

    assign req_ready = !w_full;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_addr   = r_rd_addr;
    assign busy      = !w_empty || (r_state == S_WRITE) || (r_state == S_READ);

endmodule
